// File: rtl/instr_fetch_stage.sv
// Fetch stage: loadable program memory streamed from address 0 over valid/ready until a HALT word or end of memory.
// First word valid two edges after start; one word per cycle while ready, word and pc held while ready is low.
module instr_fetch_stage #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              start,
  input  logic              instr_ready,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   issued,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic              done_q, done_d;

  logic [15:0]       mem_q [DEPTH];
  logic              load_ok;
  logic [ADDR_W-1:0] pc_inc;
  logic [15:0]       next_word;
  logic              pc_last;

  assign load_ok   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign next_word = mem_q[pc_inc];
  assign pc_last   = (pc_q == ADDR_W'(DEPTH - 1));

  // Program memory has no reset so a loaded program survives reset_n.
  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      instr_q  <= 16'h0000;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      issued_q <= issued_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d     = '0;
          issued_d = '0;
          state_d  = S_PRIME;
        end
      end
      S_PRIME: begin
        if (mem_q[0] == 16'h0000) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          instr_d = mem_q[0];
          valid_d = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (valid_q && instr_ready) begin
          issued_d = issued_q + CNT_W'(1);
          // A HALT word ends the stream without being presented, so pc stays on the last issued word.
          if (pc_last || (next_word == 16'h0000)) begin
            instr_d = 16'h0000;
            valid_d = 1'b0;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            instr_d = next_word;
            pc_d    = pc_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign issued      = issued_q;
  assign done        = done_q;
  assign busy        = (state_q == S_PRIME) || (state_q == S_STREAM);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: hand-computed vectors checked with immediate assertions.
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [3:0]  pc;
  logic [4:0]  issued;
  logic        busy;
  logic        done;

  int vectors    = 0;
  int miscompares = 0;

  instr_fetch_stage #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc          (pc),
    .issued      (issued),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] w, input logic [3:0] p);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".instr"}, {16'd0, instr_out}, {16'd0, w});
    chk({tag, ".pc"}, {28'd0, pc}, {28'd0, p});
  endtask

  task automatic chk_end(input string tag, input logic [4:0] n);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, ".instr"}, {16'd0, instr_out}, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".issued"}, {27'd0, issued}, {27'd0, n});
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; instr_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst.instr", {16'd0, instr_out}, 32'd0);
    chk("rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.pc", {28'd0, pc}, 32'd0);
    chk("rst.issued", {27'd0, issued}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    load(4'd0, 16'h1042);
    load(4'd1, 16'h2083);
    load(4'd2, 16'h3105);
    load(4'd3, 16'h0000);

    // Basic stream
    instr_ready = 1'b1;
    pulse_start();
    chk("basic.prime_busy", {31'd0, busy}, 32'd1);
    chk("basic.prime_valid", {31'd0, instr_valid}, 32'd0);
    tick(); chk_word("basic.w0", 16'h1042, 4'd0);
    tick(); chk_word("basic.w1", 16'h2083, 4'd1);
    tick(); chk_word("basic.w2", 16'h3105, 4'd2);
    tick(); chk_end("basic.end", 5'd3);
    chk("basic.end_pc", {28'd0, pc}, 32'd2);
    tick();
    chk("basic.done_drop", {31'd0, done}, 32'd0);
    chk("basic.idle_busy", {31'd0, busy}, 32'd0);

    // Backpressure; restart from DONE must not re-pulse done
    pulse_start();
    chk("bp.no_repulse", {31'd0, done}, 32'd0);
    tick(); chk_word("bp.w0", 16'h1042, 4'd0);
    instr_ready = 1'b1; tick(); chk_word("bp.w1a", 16'h2083, 4'd1);
    instr_ready = 1'b0; tick(); chk_word("bp.w1b", 16'h2083, 4'd1);
    chk("bp.issued_hold", {27'd0, issued}, 32'd1);
    instr_ready = 1'b0; tick(); chk_word("bp.w1c", 16'h2083, 4'd1);
    instr_ready = 1'b1; tick(); chk_word("bp.w2", 16'h3105, 4'd2);
    chk("bp.issued2", {27'd0, issued}, 32'd2);
    instr_ready = 1'b1; tick(); chk_end("bp.end", 5'd3);
    tick();

    // Reset mid-stream
    pulse_start();
    tick(); chk_word("rm.w0", 16'h1042, 4'd0);
    tick(); chk_word("rm.w1", 16'h2083, 4'd1);
    reset_n = 1'b0;
    #1;
    chk("rm.valid", {31'd0, instr_valid}, 32'd0);
    chk("rm.instr", {16'd0, instr_out}, 32'd0);
    chk("rm.pc", {28'd0, pc}, 32'd0);
    chk("rm.issued", {27'd0, issued}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rm.idle_busy", {31'd0, busy}, 32'd0);
    chk("rm.idle_valid", {31'd0, instr_valid}, 32'd0);
    pulse_start();
    tick(); chk_word("rm.r0", 16'h1042, 4'd0);
    tick(); chk_word("rm.r1", 16'h2083, 4'd1);
    tick(); chk_word("rm.r2", 16'h3105, 4'd2);
    tick(); chk_end("rm.end", 5'd3);

    // Busy guard: load and start ignored during STREAM
    pulse_start();
    tick(); chk_word("bg.w0", 16'h1042, 4'd0);
    load_en = 1'b1; load_addr = 4'd2; load_data = 16'hFFFF; start = 1'b1;
    tick(); chk_word("bg.w1", 16'h2083, 4'd1);
    tick(); chk_word("bg.w2", 16'h3105, 4'd2);
    load_en = 1'b0; start = 1'b0;
    tick(); chk_end("bg.end", 5'd3);
    load(4'd2, 16'hFFFF);
    pulse_start();
    tick(); chk_word("bg.r0", 16'h1042, 4'd0);
    tick(); chk_word("bg.r1", 16'h2083, 4'd1);
    tick(); chk_word("bg.r2", 16'hFFFF, 4'd2);
    tick(); chk_end("bg.rend", 5'd3);

    // Empty program
    load(4'd0, 16'h0000);
    pulse_start();
    chk("empty.k_done", {31'd0, done}, 32'd0);
    tick();
    chk_end("empty.end", 5'd0);
    tick();
    chk("empty.done_drop", {31'd0, done}, 32'd0);
    chk("empty.valid", {31'd0, instr_valid}, 32'd0);

    // End of memory; final load of word 0 coincides with start
    for (int a = 15; a >= 1; a--) load(4'(a), 16'h4001);
    load_en = 1'b1; load_addr = 4'd0; load_data = 16'h4001; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick(); chk_word("eom.w0", 16'h4001, 4'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk_word("eom.w", 16'h4001, 4'(i));
      chk("eom.issued", {27'd0, issued}, i);
    end
    tick(); chk_end("eom.end", 5'd16);
    chk("eom.pc_nowrap", {28'd0, pc}, 32'd15);
    tick();
    chk("eom.done_drop", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
